ipv4_tx_scheduler: RTL and testbench

Round-robin scheduler that shares the single layer-3 IPv4 TX bus between up to NUM_PORTS layer-4 protocol engines (ICMP, UDP, TCP, …). Each engine requests the bus, waits for a grant, then streams one complete packet (start … data … commit/drop). The scheduler forwards the granted engine's bus and per-packet metadata (payload length, destination IP, protocol) to the IPv4 stack through a one-cycle registered mux. It releases the bus on commit or drop.

---
 rtl/ipv4_tx_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_ipv4_tx_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ipv4_tx_scheduler
// Description : Round-robin arbiter sharing the layer-3 IPv4 TX bus between
//               NUM_PORTS layer-4 engines. The granted engine's strobes, data
//               and per-packet metadata pass through a one-cycle registered
//               mux. The bus is released on commit, drop or loss of request.
//               Optional build macro IPV4_TX_SCHED_WATCHDOG_EN adds a grant
//               watchdog that force-drops a packet held WATCHDOG_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ipv4_tx_scheduler #(
  parameter int NUM_PORTS       = 4,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_PORTS-1:0]      req,
  output logic [NUM_PORTS-1:0]      grant,
  input  logic [NUM_PORTS-1:0]      in_start,
  input  logic [NUM_PORTS-1:0]      in_data_valid,
  input  logic [NUM_PORTS-1:0]      in_commit,
  input  logic [NUM_PORTS-1:0]      in_drop,
  input  logic [3*NUM_PORTS-1:0]    in_bytes_valid,
  input  logic [32*NUM_PORTS-1:0]   in_data,
  input  logic [16*NUM_PORTS-1:0]   in_payload_len,
  input  logic [32*NUM_PORTS-1:0]   in_dst_ip,
  input  logic [8*NUM_PORTS-1:0]    in_protocol,
  output logic                      out_start,
  output logic                      out_data_valid,
  output logic                      out_commit,
  output logic                      out_drop,
  output logic [2:0]                out_bytes_valid,
  output logic [31:0]               out_data,
  output logic [15:0]               out_payload_len,
  output logic [31:0]               out_dst_ip,
  output logic [7:0]                out_protocol,
  output logic                      err_unsolicited,
  output logic                      err_timeout
);

  localparam int             IW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IW-1:0]  LAST_RST = IW'(NUM_PORTS - 1);
  localparam logic [15:0]    WD_LIMIT = 16'(WATCHDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [NUM_PORTS-1:0]  grant_nxt;
  logic [IW-1:0]         last_grant, last_nxt;
  logic [IW-1:0]         pick_idx, cand;
  logic                  pick_found;
  logic                  st_nxt, dv_nxt, cm_nxt, dr_nxt, to_nxt, unsol_nxt;
  logic                  g_start, g_dv, g_commit, g_drop, g_req;
  logic [31:0]           sel_data;
  logic [2:0]            sel_bytes;
  logic [15:0]           wd_cnt;
  logic                  wd_fire;

  // Strobes and payload of the currently granted port (last_grant holds its index while ACTIVE)
  assign g_start   = in_start[last_grant];
  assign g_dv      = in_data_valid[last_grant];
  assign g_commit  = in_commit[last_grant];
  assign g_drop    = in_drop[last_grant];
  assign g_req     = req[last_grant];
  assign sel_data  = in_data[32*int'(last_grant) +: 32];
  assign sel_bytes = in_bytes_valid[3*int'(last_grant) +: 3];

  // Any strobe from a port not currently holding the grant is a protocol error
  assign unsol_nxt = |((in_start | in_data_valid | in_commit | in_drop) & ~grant);

`ifdef IPV4_TX_SCHED_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;

  // Watchdog counter: zero outside ACTIVE, counts every cycle the grant is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state != S_ACTIVE) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  localparam logic WD_EN = 1'b0;
  assign wd_cnt = '0;
`endif

  // Fires on the last permitted ACTIVE cycle so the forced drop lands right after it
  assign wd_fire = WD_EN && (state == S_ACTIVE) && (wd_cnt == WD_LIMIT);

  // Round-robin search upward from last_grant+1; descending loop lets the nearest candidate win
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_grant;
    cand       = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_PORTS);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state, next-grant and forwarded-strobe logic
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_grant;
    st_nxt    = 1'b0;
    dv_nxt    = 1'b0;
    cm_nxt    = 1'b0;
    dr_nxt    = 1'b0;
    to_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          grant_nxt = NUM_PORTS'(1) << pick_idx;
          last_nxt  = pick_idx;
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (g_commit || g_drop) begin
          // Drop wins when both end strobes arrive together
          st_nxt    = g_start;
          dv_nxt    = g_dv;
          cm_nxt    = g_commit & ~g_drop;
          dr_nxt    = g_drop;
          grant_nxt = '0;
          state_nxt = S_HOLDOFF;
        end else if (!g_req) begin
          // Requester abandoned its packet: tell the stack to discard it
          dr_nxt    = 1'b1;
          grant_nxt = '0;
          state_nxt = S_HOLDOFF;
        end else if (wd_fire) begin
          dr_nxt    = 1'b1;
          to_nxt    = 1'b1;
          grant_nxt = '0;
          state_nxt = S_HOLDOFF;
        end else begin
          st_nxt = g_start;
          dv_nxt = g_dv;
        end
      end
      S_HOLDOFF: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State, grant and output register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      grant           <= '0;
      last_grant      <= LAST_RST;
      out_start       <= 1'b0;
      out_data_valid  <= 1'b0;
      out_commit      <= 1'b0;
      out_drop        <= 1'b0;
      out_bytes_valid <= '0;
      out_data        <= '0;
      err_unsolicited <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      state           <= state_nxt;
      grant           <= grant_nxt;
      last_grant      <= last_nxt;
      out_start       <= st_nxt;
      out_data_valid  <= dv_nxt;
      out_commit      <= cm_nxt;
      out_drop        <= dr_nxt;
      out_bytes_valid <= (state == S_ACTIVE) ? sel_bytes : 3'd0;
      out_data        <= (state == S_ACTIVE) ? sel_data  : 32'd0;
      err_unsolicited <= unsol_nxt;
      err_timeout     <= to_nxt;
    end
  end

  // Packet metadata is captured with the forwarded start and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_payload_len <= '0;
      out_dst_ip      <= '0;
      out_protocol    <= '0;
    end else if (st_nxt) begin
      out_payload_len <= in_payload_len[16*int'(last_grant) +: 16];
      out_dst_ip      <= in_dst_ip[32*int'(last_grant) +: 32];
      out_protocol    <= in_protocol[8*int'(last_grant) +: 8];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ipv4_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipv4_tx_scheduler
// Description : Directed scoreboard bench for ipv4_tx_scheduler. Stimulus
//               pushes the expected output record; a negedge monitor pops and
//               compares whenever the DUT raises any output strobe.
//               Honours IPV4_TX_SCHED_WATCHDOG_EN for the watchdog scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipv4_tx_scheduler;

  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   req, grant;
  logic [NP-1:0]   in_start, in_data_valid, in_commit, in_drop;
  logic [3*NP-1:0] in_bytes_valid;
  logic [32*NP-1:0] in_data, in_dst_ip;
  logic [16*NP-1:0] in_payload_len;
  logic [8*NP-1:0] in_protocol;
  logic            out_start, out_data_valid, out_commit, out_drop;
  logic [2:0]      out_bytes_valid;
  logic [31:0]     out_data, out_dst_ip;
  logic [15:0]     out_payload_len;
  logic [7:0]      out_protocol;
  logic            err_unsolicited, err_timeout;

  ipv4_tx_scheduler #(.NUM_PORTS(NP), .WATCHDOG_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .in_start(in_start), .in_data_valid(in_data_valid), .in_commit(in_commit), .in_drop(in_drop),
    .in_bytes_valid(in_bytes_valid), .in_data(in_data), .in_payload_len(in_payload_len),
    .in_dst_ip(in_dst_ip), .in_protocol(in_protocol),
    .out_start(out_start), .out_data_valid(out_data_valid), .out_commit(out_commit), .out_drop(out_drop),
    .out_bytes_valid(out_bytes_valid), .out_data(out_data), .out_payload_len(out_payload_len),
    .out_dst_ip(out_dst_ip), .out_protocol(out_protocol),
    .err_unsolicited(err_unsolicited), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st, dv, cm, dr, un, to;
    logic [31:0] data;
    logic [2:0]  bv;
    logic [15:0] len;
    logic [31:0] ip;
    logic [7:0]  proto;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] ml[NP];
  logic [31:0] mi[NP];
  logic [7:0]  mp[NP];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_start = '0; in_data_valid = '0; in_commit = '0; in_drop = '0;
  endtask

  task automatic drive(input logic [1:0] p, input bit st, input bit dv, input bit cm, input bit dr,
                       input logic [31:0] d, input logic [2:0] bv);
    in_start[p] = st; in_data_valid[p] = dv; in_commit[p] = cm; in_drop[p] = dr;
    in_data[32*p +: 32] = d;
    in_bytes_valid[3*p +: 3] = bv;
  endtask

  task automatic set_meta(input logic [1:0] p, input logic [15:0] len, input logic [31:0] ip,
                          input logic [7:0] pr);
    ml[p] = len; mi[p] = ip; mp[p] = pr;
    in_payload_len[16*p +: 16] = len;
    in_dst_ip[32*p +: 32] = ip;
    in_protocol[8*p +: 8] = pr;
  endtask

  // Expected forwarded record; metadata taken from the port's current stimulus table
  task automatic push(input int p, input bit st, input bit dv, input bit cm, input bit dr,
                      input bit un, input bit to, input logic [31:0] d, input logic [2:0] bv);
    exp_t e;
    e.st = st; e.dv = dv; e.cm = cm; e.dr = dr; e.un = un; e.to = to;
    e.data = d; e.bv = bv; e.len = ml[p]; e.ip = mi[p]; e.proto = mp[p];
    sb.push_back(e);
  endtask

  task automatic wait_grant(input string name, input logic [NP-1:0] exp);
    int n = 0;
    while (grant == '0 && n < 10) begin
      step();
      n++;
    end
    chk(name, 64'(grant), 64'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    clr();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: one-hot grant invariant plus in-order compare of every output event
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      tests++;
      if ($countones(grant) > 1) begin
        fails++;
        $display("FAIL grant_onehot: got %b expected at most one bit", grant);
      end
      if (out_start | out_data_valid | out_commit | out_drop | err_unsolicited | err_timeout) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got st/dv/cm/dr/un/to %b%b%b%b%b%b expected none",
                   out_start, out_data_valid, out_commit, out_drop, err_unsolicited, err_timeout);
        end else begin
          e = sb.pop_front();
          chk("strobes",
              64'({out_start, out_data_valid, out_commit, out_drop, err_unsolicited, err_timeout}),
              64'({e.st, e.dv, e.cm, e.dr, e.un, e.to}));
          if (e.dv) chk("data", 64'({out_bytes_valid, out_data}), 64'({e.bv, e.data}));
          if (e.st) chk("meta", 64'({out_payload_len, out_dst_ip, out_protocol}),
                        64'({e.len, e.ip, e.proto}));
        end
      end
    end
  end

  initial begin
    req = '0; clr();
    in_data = '0; in_bytes_valid = '0;
    in_payload_len = '0; in_dst_ip = '0; in_protocol = '0;
    for (int i = 0; i < NP; i++) begin
      ml[i] = '0; mi[i] = '0; mp[i] = '0;
    end
    set_meta(2'd0, 16'd12,  32'hC0A8_0001, 8'd17);
    set_meta(2'd1, 16'd20,  32'hC0A8_0101, 8'd6);
    set_meta(2'd2, 16'd4,   32'hC0A8_0002, 8'd6);
    set_meta(2'd3, 16'd100, 32'hC0A8_0003, 8'd17);

    // Reset state
    do_reset();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_strobes", 64'({out_start, out_data_valid, out_commit, out_drop, err_unsolicited, err_timeout}), 64'h0);
    chk("rst_data", 64'({out_bytes_valid, out_data, out_payload_len}), 64'h0);

    // Basic packet from port 0, then port 2 after holdoff
    req = 4'b0101;
    step();
    chk("t1_grant0", 64'(grant), 64'h1);
    drive(2'd0, 1, 1, 0, 0, 32'h1111_1111, 3'd4); push(0, 1, 1, 0, 0, 0, 0, 32'h1111_1111, 3'd4); step();
    drive(2'd0, 0, 1, 0, 0, 32'h2222_2222, 3'd4); push(0, 0, 1, 0, 0, 0, 0, 32'h2222_2222, 3'd4); step();
    drive(2'd0, 0, 1, 0, 0, 32'h3333_3333, 3'd2); push(0, 0, 1, 0, 0, 0, 0, 32'h3333_3333, 3'd2); step();
    drive(2'd0, 0, 0, 1, 0, 32'h0, 3'd0);         push(0, 0, 0, 1, 0, 0, 0, 32'h0, 3'd0);         step();
    clr(); req = 4'b0100;
    chk("t1_release", 64'(grant), 64'h0);
    step();
    chk("t1_holdoff", 64'(grant), 64'h0);
    step();
    chk("t1_grant2", 64'(grant), 64'h4);
    // Port 2: commit and drop together must forward drop only
    drive(2'd2, 1, 1, 0, 0, 32'h4444_4444, 3'd1); push(2, 1, 1, 0, 0, 0, 0, 32'h4444_4444, 3'd1); step();
    drive(2'd2, 0, 0, 1, 1, 32'h0, 3'd0);         push(2, 0, 0, 0, 1, 0, 0, 32'h0, 3'd0);         step();
    clr(); req = '0;
    step(); step();

    // Round robin over all ports with continuous requests
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] p;
      p = 2'(i % 4);
      wait_grant($sformatf("t2_rr%0d", i), 4'b0001 << p);
      drive(p, 1, 1, 0, 0, 32'h100 + 32'(i), 3'd4); push(int'(p), 1, 1, 0, 0, 0, 0, 32'h100 + 32'(i), 3'd4); step();
      drive(p, 0, 0, 1, 0, 32'h0, 3'd0);            push(int'(p), 0, 0, 1, 0, 0, 0, 32'h0, 3'd0);            step();
      clr();
    end
    req = '0;
    step(); step();

    // Unsolicited strobe from port 2 while port 1 holds the bus
    do_reset();
    req = 4'b0010;
    step();
    chk("t3_grant1", 64'(grant), 64'h2);
    drive(2'd1, 1, 1, 0, 0, 32'hA1A1_A1A1, 3'd4); push(1, 1, 1, 0, 0, 0, 0, 32'hA1A1_A1A1, 3'd4); step();
    drive(2'd1, 0, 1, 0, 0, 32'hA2A2_A2A2, 3'd4);
    drive(2'd2, 0, 1, 0, 0, 32'hDEAD_BEEF, 3'd4); push(1, 0, 1, 0, 0, 1, 0, 32'hA2A2_A2A2, 3'd4); step();
    drive(2'd2, 0, 0, 0, 0, 32'h0, 3'd0);
    drive(2'd1, 0, 1, 0, 0, 32'hA3A3_A3A3, 3'd3); push(1, 0, 1, 0, 0, 0, 0, 32'hA3A3_A3A3, 3'd3); step();
    drive(2'd1, 0, 0, 1, 0, 32'h0, 3'd0);         push(1, 0, 0, 1, 0, 0, 0, 32'h0, 3'd0);         step();
    clr(); req = '0;
    step(); step();

    // Request withdrawn mid-packet, then metadata latching on port 3
    do_reset();
    set_meta(2'd3, 16'h0040, 32'h0A00_0001, 8'h01);
    req = 4'b1001;
    step();
    chk("t4_grant0", 64'(grant), 64'h1);
    drive(2'd0, 1, 1, 0, 0, 32'hB1B1_B1B1, 3'd4); push(0, 1, 1, 0, 0, 0, 0, 32'hB1B1_B1B1, 3'd4); step();
    drive(2'd0, 0, 1, 0, 0, 32'hB2B2_B2B2, 3'd4); push(0, 0, 1, 0, 0, 0, 0, 32'hB2B2_B2B2, 3'd4); step();
    clr(); req = 4'b1000;                         push(0, 0, 0, 0, 1, 0, 0, 32'h0, 3'd0);         step();
    chk("t4_release", 64'(grant), 64'h0);
    step();
    chk("t4_holdoff", 64'(grant), 64'h0);
    step();
    chk("t4_grant3", 64'(grant), 64'h8);
    drive(2'd3, 1, 1, 0, 0, 32'hC1C1_C1C1, 3'd4); push(3, 1, 1, 0, 0, 0, 0, 32'hC1C1_C1C1, 3'd4); step();
    drive(2'd3, 0, 1, 0, 0, 32'hC2C2_C2C2, 3'd4); push(3, 0, 1, 0, 0, 0, 0, 32'hC2C2_C2C2, 3'd4); step();
    drive(2'd3, 0, 0, 1, 0, 32'h0, 3'd0);         push(3, 0, 0, 1, 0, 0, 0, 32'h0, 3'd0);         step();
    clr(); req = '0;
    set_meta(2'd3, 16'hFFFF, 32'hFFFF_FFFF, 8'hFF);
    step(); step(); step();
    chk("t5_meta_hold", 64'({out_payload_len, out_dst_ip, out_protocol}), 64'({16'h0040, 32'h0A00_0001, 8'h01}));
    req = 4'b0001;
    step();
    chk("t5_grant0", 64'(grant), 64'h1);
    drive(2'd0, 1, 0, 0, 0, 32'h0, 3'd0); push(0, 1, 0, 0, 0, 0, 0, 32'h0, 3'd0); step();
    drive(2'd0, 0, 0, 1, 0, 32'h0, 3'd0); push(0, 0, 0, 1, 0, 0, 0, 32'h0, 3'd0); step();
    clr(); req = '0;
    step(); step();

    // Stuck requester on port 2
    do_reset();
    req = 4'b0100;
    step();
    chk("t6_grant2", 64'(grant), 64'h4);
`ifdef IPV4_TX_SCHED_WATCHDOG_EN
    repeat (15) step();
    push(2, 0, 0, 0, 1, 0, 1, 32'h0, 3'd0);
    step();
    chk("t6_wd_release", 64'(grant), 64'h0);
    step();
    chk("t6_wd_holdoff", 64'(grant), 64'h0);
    step();
    chk("t6_wd_regrant", 64'(grant), 64'h4);
    req = '0;
    push(2, 0, 0, 0, 1, 0, 0, 32'h0, 3'd0);
    step();
    chk("t6_final_release", 64'(grant), 64'h0);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk($sformatf("t6_hold%0d", i), 64'(grant), 64'h4);
    end
    req = '0;
    push(2, 0, 0, 0, 1, 0, 0, 32'h0, 3'd0);
    step();
    chk("t6_final_release", 64'(grant), 64'h0);
`endif
    step(); step();
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
